pulse_blinker: RTL and testbench



---
 rtl/pulse_blinker.sv | 130 +++++++++++++
 tb/tb_pulse_blinker.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pulse_blinker.sv
// Turns single-cycle event pulses into slow, human-visible LED blinks, one blink per event.
// Optional sticky dropped-event flag enabled with the PULSE_BLINKER_OVF_EN macro.
module pulse_blinker #(
  parameter int ON_TICKS  = 4,
  parameter int OFF_TICKS = 4,
  parameter int CNT_W     = 4
) (
  input  logic             regular_clk,
  input  logic             reset_n,
  input  logic             slow_clk,
  input  logic             event_pulse,
  output logic             led_out,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             overflow
);

  localparam int MAX_T = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int TW    = $clog2(MAX_T + 1);
  localparam logic [TW-1:0]    ON_LAST  = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0]    OFF_LAST = TW'(OFF_TICKS - 1);
  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    tick_q, tick_d;
  logic             entry_q, entry_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             led_q, busy_q;
  logic             consume, drop, tick_en;

  // The first cycle of each phase ignores slow_clk so a phase never starts half-counted.
  assign tick_en = slow_clk && !entry_q;

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    entry_d = 1'b0;
    consume = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pend_q != '0) begin
          state_d = S_ON;
          consume = 1'b1;
          tick_d  = '0;
          entry_d = 1'b1;
        end
      end
      S_ON: begin
        if (tick_en) begin
          if (tick_q == ON_LAST) begin
            state_d = S_OFF;
            tick_d  = '0;
            entry_d = 1'b1;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      S_OFF: begin
        if (tick_en) begin
          if (tick_q == OFF_LAST) begin
            tick_d = '0;
            if (pend_q != '0) begin
              state_d = S_ON;
              consume = 1'b1;
              entry_d = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A new event while full and not consuming is lost; event+consume nets to zero.
  always_comb begin
    drop   = event_pulse && !consume && (pend_q == PEND_MAX);
    pend_d = pend_q;
    if (event_pulse && !consume && !drop) begin
      pend_d = pend_q + 1'b1;
    end else if (!event_pulse && consume) begin
      pend_d = pend_q - 1'b1;
    end
  end

  always_ff @(posedge regular_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      entry_q <= 1'b0;
      pend_q  <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      entry_q <= entry_d;
      pend_q  <= pend_d;
      led_q   <= (state_d == S_ON);
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign led_out = led_q;
  assign busy    = busy_q;
  assign pending = pend_q;

`ifdef PULSE_BLINKER_OVF_EN
  logic ovf_q;

  always_ff @(posedge regular_clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_blinker.sv
// Directed bench for pulse_blinker: two instances (4/4/4 paced, 1/1/2 with slow_clk stuck high)
// checked every cycle against a phase/countdown model plus hand-computed points.
module tb_pulse_blinker;

`ifdef PULSE_BLINKER_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst1_n = 1'b1, rst2_n = 1'b1;
  logic sc1 = 1'b0, ev1 = 1'b0, sc2 = 1'b1, ev2 = 1'b0;
  logic       led1, busy1, ovf1, led2, busy2, ovf2;
  logic [3:0] pend1;
  logic [1:0] pend2;

  int total = 0, passed = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pulse_blinker #(.ON_TICKS(4), .OFF_TICKS(4), .CNT_W(4)) u1 (
    .regular_clk(clk), .reset_n(rst1_n), .slow_clk(sc1), .event_pulse(ev1),
    .led_out(led1), .busy(busy1), .pending(pend1), .overflow(ovf1));

  pulse_blinker #(.ON_TICKS(1), .OFF_TICKS(1), .CNT_W(2)) u2 (
    .regular_clk(clk), .reset_n(rst2_n), .slow_clk(sc2), .event_pulse(ev2),
    .led_out(led2), .busy(busy2), .pending(pend2), .overflow(ovf2));

  // phase: 0 idle, 1 lit, 2 dark gap; left = counted ticks still owed in the phase
  typedef struct packed {
    int phase;
    int left;
    bit fresh;
    int pend;
    bit ovf;
  } mdl_t;

  mdl_t m1, m2;

  function automatic mdl_t mstep(mdl_t m, bit ev, bit tk, int on_t, int off_t, int maxp);
    mdl_t n = m;
    bit start = 1'b0;
    n.fresh = 1'b0;
    if (m.phase == 0) begin
      start = (m.pend != 0);
    end else if (tk && !m.fresh) begin
      if (m.left > 1) n.left = m.left - 1;
      else if (m.phase == 1) begin
        n.phase = 2; n.left = off_t; n.fresh = 1'b1;
      end else if (m.pend != 0) start = 1'b1;
      else n.phase = 0;
    end
    if (start) begin
      n.phase = 1; n.left = on_t; n.fresh = 1'b1; n.pend = m.pend - 1;
    end
    if (ev) begin
      if (n.pend < maxp) n.pend = n.pend + 1;
      else n.ovf = 1'b1;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst1_n)
    if (!rst1_n) m1 <= '0;
    else m1 <= mstep(m1, ev1, sc1, 4, 4, 15);

  always @(posedge clk or negedge rst2_n)
    if (!rst2_n) m2 <= '0;
    else m2 <= mstep(m2, ev2, sc2, 1, 1, 3);

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("u1.led", int'(led1), int'(m1.phase == 1));
      chk("u1.busy", int'(busy1), int'(m1.phase != 0));
      chk("u1.pending", int'(pend1), m1.pend);
      chk("u1.overflow", int'(ovf1), int'(OVF_EN && m1.ovf));
      chk("u2.led", int'(led2), int'(m2.phase == 1));
      chk("u2.busy", int'(busy2), int'(m2.phase != 0));
      chk("u2.pending", int'(pend2), m2.pend);
      chk("u2.overflow", int'(ovf2), int'(OVF_EN && m2.ovf));
    end
  end

  task automatic step(input bit e1, input bit s1, input bit e2);
    ev1 = e1; sc1 = s1; ev2 = e2;
    @(posedge clk); #1;
  endtask

  initial begin
    int led_n, busy_n, rise, fall;
    bit prev_led, prev_busy;

    #2 rst1_n = 1'b0; rst2_n = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst1_n = 1'b1; rst2_n = 1'b1;
    chk("rst.u1", int'({led1, busy1, ovf1, pend1}), 0);
    chk("rst.u2", int'({led2, busy2, ovf2, pend2}), 0);

    // Small counter, slow_clk stuck high: saturation and 2-cycle ON/OFF alternation
    step(0, 0, 1); chk("sat.e0.pend", int'(pend2), 1);
    step(0, 0, 1); chk("sat.e1.led", int'(led2), 1); chk("sat.e1.pend", int'(pend2), 1);
    step(0, 0, 1); chk("sat.e2.led", int'(led2), 1); chk("sat.e2.pend", int'(pend2), 2);
    step(0, 0, 1); chk("sat.e3.led", int'(led2), 0); chk("sat.e3.pend", int'(pend2), 3);
    step(0, 0, 1); chk("sat.e4.pend", int'(pend2), 3); chk("sat.e4.ovf", int'(ovf2), int'(OVF_EN));
    step(0, 0, 1); chk("sat.e5.led", int'(led2), 1); chk("sat.e5.pend", int'(pend2), 3);
    led_n = 0; rise = 0; prev_led = 1'b1;
    for (int k = 0; k < 30; k++) begin
      step(0, 0, 0);
      if (led2) led_n++;
      if (led2 && !prev_led) rise++;
      prev_led = led2;
    end
    chk("sat.high_cycles", led_n, 7);
    chk("sat.blinks_after", rise, 3);
    chk("sat.end.busy", int'(busy2), 0);
    chk("sat.end.pend", int'(pend2), 0);
    chk("sat.ovf_sticky", int'(ovf2), int'(OVF_EN));

    // Single event, slow_clk every 8 cycles
    step(1, 0, 0);
    chk("one.e0.pend", int'(pend1), 1); chk("one.e0.led", int'(led1), 0);
    step(0, 0, 0);
    chk("one.e1.led", int'(led1), 1); chk("one.e1.pend", int'(pend1), 0);
    led_n = 0; busy_n = 0;
    for (int k = 0; k < 70; k++) begin
      if (led1) led_n++;
      if (busy1) busy_n++;
      step(0, (k % 8) == 3, 0);
    end
    chk("one.led_cycles", led_n, 28);
    chk("one.busy_cycles", busy_n, 60);
    chk("one.end.pend", int'(pend1), 0);

    // Three back-to-back events: blinks chain OFF->ON without passing through IDLE
    step(1, 0, 0); chk("three.e0.pend", int'(pend1), 1);
    step(1, 0, 0); chk("three.e1.pend", int'(pend1), 1); chk("three.e1.led", int'(led1), 1);
    step(1, 0, 0); chk("three.e2.pend", int'(pend1), 2);
    rise = 0; fall = 0; prev_led = 1'b1; prev_busy = 1'b1;
    for (int k = 0; k < 120; k++) begin
      step(0, (k % 3) == 0, 0);
      if (led1 && !prev_led) rise++;
      if (!busy1 && prev_busy) fall++;
      prev_led = led1; prev_busy = busy1;
    end
    chk("three.more_blinks", rise, 2);
    chk("three.busy_falls", fall, 1);
    chk("three.end.busy", int'(busy1), 0);

    // Event coinciding with an OFF->ON consume, then asynchronous reset mid-ON
    step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
    repeat (4) step(0, 1, 0);
    chk("coin.off.led", int'(led1), 0); chk("coin.off.pend", int'(pend1), 2);
    repeat (4) step(0, 1, 0);
    chk("coin.pre.busy", int'(busy1), 1); chk("coin.pre.led", int'(led1), 0);
    step(1, 1, 0);
    chk("coin.led", int'(led1), 1); chk("coin.pend", int'(pend1), 2);
    repeat (3) step(1, 0, 0);
    chk("rst_mid.pend_before", int'(pend1), 5); chk("rst_mid.led_before", int'(led1), 1);
    #2 rst1_n = 1'b0;
    #1;
    chk("rst_mid.led", int'(led1), 0); chk("rst_mid.busy", int'(busy1), 0);
    chk("rst_mid.pend", int'(pend1), 0); chk("rst_mid.ovf", int'(ovf1), 0);
    @(posedge clk); #1 rst1_n = 1'b1;
    led_n = 0;
    for (int k = 0; k < 40; k++) begin
      step(0, 1, 0);
      if (led1 || busy1) led_n++;
    end
    chk("rst_mid.no_blink", led_n, 0);

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
